// File: rtl/data_memory_responder_pkg.sv
// Shared CPU-side definitions for the data-memory responder: FSM encodings,
// parameter defaults, load/store opcodes and the address legality check.
package data_memory_responder_pkg;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 2;
    localparam int LAT_CNT_W       = 4;

    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Word accesses only: low two bits must be zero and the word index in range.
    function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth_words));
    endfunction

endpackage

// File: rtl/data_memory_responder_array.sv
// DEPTH_WORDS x 32 storage: combinational read, write on rising clk when enabled.
// No flow control; contents are never reset.
module data_memory_array
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wr_dat,
    output logic [31:0]   o_rd_dat
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_addr];

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency LW/SW responder: one request in flight, response LATENCY edges after accept.
// reqReady only in IDLE; responses cannot be backpressured.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] address,
    input  logic        writeEnable,
    input  logic [31:0] dataIn,
    output logic        respValid,
    output logic [31:0] dataOut,
    output logic        addrError
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t                 r_state;
    state_t                 w_next;
    logic [LAT_CNT_W-1:0]   r_lat_cnt;
    logic [AW-1:0]          r_word;
    logic [6:0]             r_op;
    logic [31:0]            r_wdat;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_lat_done;
    logic                   w_commit;
    logic [31:0]            w_rd_dat;

    assign w_accept   = reqValid && reqReady;
    // Only consulted in BUSY, which LATENCY=1 never enters.
    assign w_lat_done = (r_lat_cnt == LAT_CNT_W'(LATENCY - 2));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (LATENCY == 1) ? ST_RESPOND : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_lat_done) begin
                    w_next = ST_RESPOND;
                end
            end
            ST_RESPOND: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_lat_cnt <= '0;
            r_word    <= '0;
            r_op      <= '0;
            r_wdat    <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_lat_cnt <= '0;
            r_word    <= address[AW+1:2];
            r_op      <= writeEnable ? OPC_SW : OPC_LW;
            r_wdat    <= dataIn;
            r_err     <= addr_err(address, DEPTH_WORDS);
        end else if (r_state == ST_BUSY) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
        end
    end

    // Outputs and the store commit are gated by resetN so an asserted reset
    // silences RESPOND immediately and drops a store committing on that edge.
    always_comb begin
        reqReady  = 1'b0;
        respValid = 1'b0;
        dataOut   = '0;
        addrError = 1'b0;
        w_commit  = 1'b0;
        if (resetN) begin
            unique case (r_state)
                ST_IDLE: reqReady = 1'b1;
                ST_RESPOND: begin
                    respValid = 1'b1;
                    addrError = r_err;
                    if (!r_err && (r_op == OPC_LW)) begin
                        dataOut = w_rd_dat;
                    end
                    w_commit = !r_err && (r_op == OPC_SW);
                end
                default: ;
            endcase
        end
    end

    data_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk      (clk),
        .i_wr_en  (w_commit),
        .i_addr   (r_word),
        .i_wr_dat (r_wdat),
        .o_rd_dat (w_rd_dat)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: LATENCY=2 instance driven from a vector table plus multi-cycle
// sequences, and a LATENCY=1 instance for store-then-load latency.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        resetN;

    logic        a_vld, a_rdy, a_we, a_resp, a_err;
    logic [31:0] a_addr, a_din, a_dout;
    logic        b_vld, b_rdy, b_we, b_resp, b_err;
    logic [31:0] b_addr, b_din, b_dout;

    bit          sel_b;
    logic        s_rdy, s_resp, s_err;
    logic [31:0] s_dout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk(clk), .resetN(resetN), .reqValid(a_vld), .reqReady(a_rdy),
        .address(a_addr), .writeEnable(a_we), .dataIn(a_din),
        .respValid(a_resp), .dataOut(a_dout), .addrError(a_err)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
        .clk(clk), .resetN(resetN), .reqValid(b_vld), .reqReady(b_rdy),
        .address(b_addr), .writeEnable(b_we), .dataIn(b_din),
        .respValid(b_resp), .dataOut(b_dout), .addrError(b_err)
    );

    assign s_rdy  = sel_b ? b_rdy  : a_rdy;
    assign s_resp = sel_b ? b_resp : a_resp;
    assign s_err  = sel_b ? b_err  : a_err;
    assign s_dout = sel_b ? b_dout : a_dout;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic vld, input logic we, input logic [31:0] addr, input logic [31:0] din);
        if (sel_b) begin
            b_vld = vld; b_we = we; b_addr = addr; b_din = din;
        end else begin
            a_vld = vld; a_we = we; a_addr = addr; a_din = din;
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after the response.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] din, input logic [31:0] exp_dat,
                          input logic exp_err, input int lat);
        int n;
        n = 0;
        while (!s_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, {31'b0, s_rdy}, 32'd1);
        drive(1'b1, we, addr, din);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n = 1;
        while (!s_resp && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " data"}, s_dout, exp_dat);
        check({tag, " err"}, {31'b0, s_err}, {31'b0, exp_err});
        @(negedge clk);
        check({tag, " resp_single"}, {31'b0, s_resp}, 32'd0);
        check({tag, " idle_data"}, s_dout, 32'h0);
        check({tag, " idle_err"}, {31'b0, s_err}, 32'd0);
    endtask

    initial begin
        int hits;
        logic [8:0] exp_rdy;
        logic [8:0] exp_rsp;

        vecs[0]  = '{1'b1, 32'h0000_001C, 32'h0000_0003, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0003, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_001E, 32'h0,         32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0400, 32'h0000_0055, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_001E, 32'h0000_0077, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0003, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1111_1111, 1'b0};

        resetN = 1'b0;
        sel_b  = 1'b0;
        a_vld = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_vld = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        repeat (2) @(negedge clk);

        check("rst ready", {31'b0, a_rdy}, 32'd0);
        check("rst resp", {31'b0, a_resp}, 32'd0);
        check("rst data", a_dout, 32'h0);
        check("rst err", {31'b0, a_err}, 32'd0);
        resetN = 1'b1;
        #1;
        check("post-rst ready", {31'b0, a_rdy}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].din,
                   vecs[i].exp_dat, vecs[i].exp_err, 2);
        end

        // reqValid held high: one accept every LATENCY+1 cycles.
        exp_rdy = 9'b001_001_001;
        exp_rsp = 9'b100_100_100;
        drive(1'b1, 1'b0, 32'h0000_001C, 32'h0);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("b2b ready c%0d", i), {31'b0, a_rdy}, {31'b0, exp_rdy[i]});
            check($sformatf("b2b resp c%0d", i), {31'b0, a_resp}, {31'b0, exp_rsp[i]});
            if (exp_rsp[i]) check($sformatf("b2b data c%0d", i), a_dout, 32'h3);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b idle ready", {31'b0, a_rdy}, 32'd1);

        // Reset while a store sits in BUSY: response and write must vanish.
        drive(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        resetN = 1'b0;
        #1;
        check("rstbusy ready", {31'b0, a_rdy}, 32'd0);
        hits = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (a_resp) hits++;
        end
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_resp) hits++;
        end
        check("rstbusy no resp", 32'(hits), 32'd0);
        do_req("rstbusy load", 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111, 1'b0, 2);

        // Reset asserted during RESPOND of a store: outputs drop, no commit.
        drive(1'b1, 1'b1, 32'h0000_001C, 32'h0000_0BAD);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstresp resp before", {31'b0, a_resp}, 32'd1);
        resetN = 1'b0;
        #1;
        check("rstresp resp gated", {31'b0, a_resp}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        do_req("rstresp load", 1'b0, 32'h0000_001C, 32'h0, 32'h0000_0003, 1'b0, 2);

        // LATENCY=1 instance: store then immediate load of the same word.
        sel_b = 1'b1;
        #1;
        do_req("lat1 store", 1'b1, 32'h0000_0010, 32'h0000_00CB, 32'h0, 1'b0, 1);
        do_req("lat1 load", 1'b0, 32'h0000_0010, 32'h0, 32'h0000_00CB, 1'b0, 1);
        do_req("lat1 misalign", 1'b0, 32'h0000_0011, 32'h0, 32'h0, 1'b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
